array_allocator: RTL and testbench
==================================

// Module: array_allocator
// PURPOSE
//  Array-handle allocator feeding the heap move/copy stage (moveLong, heap mov): hands out array ids,
//  recycles freed ids via a LIFO freed-array stack, tracks per-array size. Ids index heapMem as
//  id*NArea+offset downstream. Replaces inline allocs/freedArrays/arraySizes logic of program FSM.
// PARAMETERS
//  MemoryElementWidth  12   width of ids, sizes, counters
//  NArrays             20   max distinct array ids (0..NArrays-1); freed stack depth = NArrays
//  NArea               10   words per array area; size writes clamp to NArea
// PORTS
//  clock        in   1    single clock, all state on posedge
//  reset        in   1    asynchronous, active-low; clears all state, enters INIT
//  ready        out  1    high in READY state only
//  alloc_req    in   1    request one array id (sampled when ready)
//  alloc_ack    out  1    one-cycle pulse: alloc_id valid
//  alloc_fail   out  1    one-cycle pulse: no id available
//  alloc_id     out  W    allocated id, held until next alloc_ack
//  free_req     in   1    return free_id to pool
//  free_id      in   W    id being freed
//  free_ack     out  1    one-cycle pulse: free accepted
//  free_err     out  1    one-cycle pulse: free rejected, no state change
//  size_we      in   1    write arraySizes[size_id] <= min(size_val,NArea)
//  size_id      in   W    ; size_val in W ; size_rd_id in W
//  size_rd_val  out  W    registered arraySizes[size_rd_id], 1-cycle latency
//  allocs       out  W    high-water count of ids ever issued (never decreases)
//  in_use       out  W    allocs minus freed-stack occupancy
// BEHAVIOUR
//  - Reset (async, active-low): ready/acks/fails/errs=0, alloc_id=0, allocs=0, stack top=0, in_use=0,
//    size_rd_val=0; state=INIT.
//  - INIT: clears arraySizes one entry/cycle, idx 0..NArrays-1 (NArrays cycles), then READY.
//    Requests in INIT ignored (no ack, no fail, no err). Reset mid-INIT or mid-READY restarts INIT.
//  - READY: alloc/free/size_we each evaluated every cycle; responses registered, latency 1.
//  - Alloc: stack non-empty -> pop top (LIFO); else allocs<NArrays -> id=allocs, allocs+=1;
//    else alloc_fail. On success arraySizes[id]<=0 in same update.
//  - Free: free_id>=allocs or stack full -> free_err; else push, free_ack.
//  - Simultaneous alloc+free (valid): free first, alloc sees post-free state -> freed id returned
//    directly as alloc_id (bypass); stack depth unchanged; both acks pulse.
//  - size_we same cycle as alloc of same id: alloc clear wins (size=0). size_rd reflects
//    pre-update contents (read-before-write).
//  - Counters saturate at NArrays; no wrap. in_use = allocs - stack_top, combinational from regs.
//  - States: INIT -> READY (after NArrays clears); any -> INIT on reset. No other transitions.
// CONFIGURATION
//  ARRAY_ALLOC_DOUBLE_FREE_CHECK_EN defined: per-id live bitmap (set on alloc, cleared on free);
//    free of non-live id -> free_err, no push; alloc+free bypass of same id allowed.
//  Not defined: range check only (free_id<allocs); double free accepted and pushed twice.
// STRUCTURE
//  Shared package zero_pkg: word_t (logic [MemoryElementWidth-1:0]), alloc_state_t {INIT,READY},
//    NArrays/NArea defaults as localparams.
//  Sub-module freed_stack: LIFO depth NArrays, push/pop/top/count/full/empty, push+pop same cycle
//    allowed; allocator owns sizes table, counters, FSM.
// TESTING
//  1 reset low 3 cycles, release -> ready rises exactly NArrays(20) cycles later; all sizes read 0.
//  2 three allocs -> ids 0,1,2, allocs=3, in_use=3; free 1 then alloc -> id 1 (LIFO), allocs=3.
//  3 alloc 20 times -> ids 0..19; 21st -> alloc_fail, allocs stays 20; free 7 + alloc same cycle
//    -> alloc_id=7, both acks, in_use=20.
//  4 free_id=5 with allocs=3 -> free_err, stack unchanged; with _EN, free 1 twice -> 2nd free_err.
//  5 size_we id0 val 15 -> size_rd_val=10 (clamped); realloc id0 after free -> size reads 0.
//  6 assert reset during READY with 4 ids live -> all outputs 0 next edge, INIT re-run, ids restart at 0.

Source files
------------

// File: rtl/zero_pkg.sv
// Shared types and defaults for the array-handle allocator and its freed-id stack.
package zero_pkg;
  localparam int MemoryElementWidth = 12;
  localparam int NArraysDefault     = 20;
  localparam int NAreaDefault       = 10;

  typedef logic [MemoryElementWidth-1:0] word_t;
  typedef enum logic {INIT, READY} alloc_state_t;

  function automatic word_t clamp_size(input word_t val, input word_t limit);
    return (val > limit) ? limit : val;
  endfunction
endpackage

// File: rtl/array_allocator_freed_stack.sv
// LIFO of freed array ids. Push and pop in the same cycle replace the current top entry.
module freed_stack
  import zero_pkg::*;
#(
  parameter int Depth = NArraysDefault
) (
  input  logic  clock,
  input  logic  reset,
  input  logic  push,
  input  word_t push_data,
  input  logic  pop,
  output word_t top,
  output word_t count,
  output logic  full,
  output logic  empty
);
  localparam int IdxW = $clog2(Depth);
  localparam word_t DepthW = word_t'(Depth);
  localparam logic [IdxW-1:0] IdxOne = IdxW'(1);

  word_t           mem [Depth];
  word_t           count_q, count_d;
  logic [IdxW-1:0] top_idx, wr_idx;
  logic            wr_en;

  assign empty   = (count_q == '0);
  assign full    = (count_q == DepthW);
  assign top_idx = count_q[IdxW-1:0] - IdxOne;
  assign top     = empty ? '0 : mem[top_idx];
  assign count   = count_q;

  always_comb begin
    count_d = count_q;
    wr_en   = 1'b0;
    wr_idx  = count_q[IdxW-1:0];
    if (push && pop && !empty) begin
      wr_en  = 1'b1;
      wr_idx = top_idx;
    end else if (push && !full) begin
      wr_en   = 1'b1;
      count_d = count_q + word_t'(1);
    end else if (pop && !empty) begin
      count_d = count_q - word_t'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) count_q <= '0;
    else        count_q <= count_d;
  end

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_idx] <= push_data;
  end
endmodule

// File: rtl/array_allocator.sv
// Array-id allocator with LIFO recycling of freed ids and a per-array size table.
// Define ARRAY_ALLOC_DOUBLE_FREE_CHECK_EN to reject frees of ids that are not currently live.
module array_allocator
  import zero_pkg::*;
#(
  parameter int NArrays = NArraysDefault,
  parameter int NArea   = NAreaDefault
) (
  input  logic  clock,
  input  logic  reset,
  output logic  ready,
  input  logic  alloc_req,
  output logic  alloc_ack,
  output logic  alloc_fail,
  output word_t alloc_id,
  input  logic  free_req,
  input  word_t free_id,
  output logic  free_ack,
  output logic  free_err,
  input  logic  size_we,
  input  word_t size_id,
  input  word_t size_val,
  input  word_t size_rd_id,
  output word_t size_rd_val,
  output word_t allocs,
  output word_t in_use
);
  localparam int    IdxW     = $clog2(NArrays);
  localparam word_t NArraysW = word_t'(NArrays);
  localparam word_t LastIdx  = word_t'(NArrays - 1);
  localparam word_t NAreaW   = word_t'(NArea);

  alloc_state_t state_q, state_d;
  word_t        init_idx_q, init_idx_d;
  word_t        allocs_q, allocs_d;
  word_t        alloc_id_q, alloc_id_d;
  word_t        size_rd_val_q, size_rd_val_d;
  logic         alloc_ack_q, alloc_ack_d;
  logic         alloc_fail_q, alloc_fail_d;
  logic         free_ack_q, free_ack_d;
  logic         free_err_q, free_err_d;

  logic            st_push, st_pop, st_full, st_empty;
  word_t           st_top, st_count;
  logic            free_ok, free_live;
  logic            clr_we, user_we;
  logic [IdxW-1:0] clr_idx, free_idx;

  word_t sizes_mem [NArrays];

  freed_stack #(.Depth(NArrays)) u_stack (
    .clock     (clock),
    .reset     (reset),
    .push      (st_push),
    .push_data (free_id),
    .pop       (st_pop),
    .top       (st_top),
    .count     (st_count),
    .full      (st_full),
    .empty     (st_empty)
  );

  assign free_idx = free_id[IdxW-1:0];

`ifdef ARRAY_ALLOC_DOUBLE_FREE_CHECK_EN
  logic [NArrays-1:0] live_q, live_d;
  assign free_live = live_q[free_idx];

  // Clear before set so an alloc+free bypass of the same id leaves it live.
  always_comb begin
    live_d = live_q;
    if (free_ok)     live_d[free_idx] = 1'b0;
    if (alloc_ack_d) live_d[alloc_id_d[IdxW-1:0]] = 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) live_q <= '0;
    else        live_q <= live_d;
  end
`else
  assign free_live = 1'b1;
`endif

  assign free_ok = (state_q == READY) && free_req && (free_id < allocs_q)
                   && !st_full && free_live;

  always_comb begin
    state_d      = state_q;
    init_idx_d   = init_idx_q;
    allocs_d     = allocs_q;
    alloc_id_d   = alloc_id_q;
    alloc_ack_d  = 1'b0;
    alloc_fail_d = 1'b0;
    free_ack_d   = 1'b0;
    free_err_d   = 1'b0;
    st_push      = 1'b0;
    st_pop       = 1'b0;
    clr_we       = 1'b0;
    clr_idx      = init_idx_q[IdxW-1:0];
    user_we      = 1'b0;
    case (state_q)
      INIT: begin
        clr_we = 1'b1;
        if (init_idx_q == LastIdx) begin
          state_d    = READY;
          init_idx_d = '0;
        end else begin
          init_idx_d = init_idx_q + word_t'(1);
        end
      end
      READY: begin
        free_ack_d = free_ok;
        free_err_d = free_req && !free_ok;
        user_we    = size_we && (size_id < NArraysW);
        // A valid free in the same cycle hands its id straight back to the allocator.
        if (alloc_req) begin
          if (free_ok) begin
            alloc_ack_d = 1'b1;
            alloc_id_d  = free_id;
          end else if (!st_empty) begin
            alloc_ack_d = 1'b1;
            alloc_id_d  = st_top;
            st_pop      = 1'b1;
          end else if (allocs_q < NArraysW) begin
            alloc_ack_d = 1'b1;
            alloc_id_d  = allocs_q;
            allocs_d    = allocs_q + word_t'(1);
          end else begin
            alloc_fail_d = 1'b1;
          end
        end else begin
          st_push = free_ok;
        end
        if (alloc_ack_d) begin
          clr_we  = 1'b1;
          clr_idx = alloc_id_d[IdxW-1:0];
        end
      end
      default: state_d = INIT;
    endcase
  end

  assign size_rd_val_d = (size_rd_id < NArraysW) ? sizes_mem[size_rd_id[IdxW-1:0]] : '0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= INIT;
      init_idx_q    <= '0;
      allocs_q      <= '0;
      alloc_id_q    <= '0;
      size_rd_val_q <= '0;
      alloc_ack_q   <= 1'b0;
      alloc_fail_q  <= 1'b0;
      free_ack_q    <= 1'b0;
      free_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      init_idx_q    <= init_idx_d;
      allocs_q      <= allocs_d;
      alloc_id_q    <= alloc_id_d;
      size_rd_val_q <= size_rd_val_d;
      alloc_ack_q   <= alloc_ack_d;
      alloc_fail_q  <= alloc_fail_d;
      free_ack_q    <= free_ack_d;
      free_err_q    <= free_err_d;
    end
  end

  // The allocation clear is written last so it overrides a same-cycle size write.
  always_ff @(posedge clock) begin
    if (user_we) sizes_mem[size_id[IdxW-1:0]] <= clamp_size(size_val, NAreaW);
    if (clr_we)  sizes_mem[clr_idx] <= '0;
  end

  assign ready       = (state_q == READY);
  assign alloc_ack   = alloc_ack_q;
  assign alloc_fail  = alloc_fail_q;
  assign alloc_id    = alloc_id_q;
  assign free_ack    = free_ack_q;
  assign free_err    = free_err_q;
  assign size_rd_val = size_rd_val_q;
  assign allocs      = allocs_q;
  assign in_use      = allocs_q - st_count;
endmodule

// File: tb/tb_array_allocator.sv
// Scoreboard bench for array_allocator: expected responses are queued at issue time and
// checked by an independent monitor; counters and size reads are checked directly.
module tb_array_allocator;
  import zero_pkg::*;

  logic  clock = 1'b0;
  logic  reset;
  logic  ready, alloc_req, alloc_ack, alloc_fail, free_req, free_ack, free_err, size_we;
  word_t alloc_id, free_id, size_id, size_val, size_rd_id, size_rd_val, allocs, in_use;

  typedef struct packed {
    logic  a_ack;
    logic  a_fail;
    word_t a_id;
    logic  f_ack;
    logic  f_err;
  } resp_t;

  resp_t exp_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    n_txn = 0;

  array_allocator dut (
    .clock       (clock),
    .reset       (reset),
    .ready       (ready),
    .alloc_req   (alloc_req),
    .alloc_ack   (alloc_ack),
    .alloc_fail  (alloc_fail),
    .alloc_id    (alloc_id),
    .free_req    (free_req),
    .free_id     (free_id),
    .free_ack    (free_ack),
    .free_err    (free_err),
    .size_we     (size_we),
    .size_id     (size_id),
    .size_val    (size_val),
    .size_rd_id  (size_rd_id),
    .size_rd_val (size_rd_val),
    .allocs      (allocs),
    .in_use      (in_use)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: actual=%0d required=%0d", nm, act, req);
    end
  endtask

  task automatic exp_resp(input logic aa, input logic af, input int id,
                          input logic fa, input logic fe);
    resp_t r;
    r.a_ack  = aa;
    r.a_fail = af;
    r.a_id   = word_t'(id);
    r.f_ack  = fa;
    r.f_err  = fe;
    exp_q.push_back(r);
  endtask

  task automatic cyc(input logic a, input logic f, input int fid);
    alloc_req = a;
    free_req  = f;
    free_id   = word_t'(fid);
    @(posedge clock);
    #1;
    alloc_req = 1'b0;
    free_req  = 1'b0;
    size_we   = 1'b0;
  endtask

  task automatic rd_size(input int id, input int want, input string nm);
    size_rd_id = word_t'(id);
    @(posedge clock);
    #1;
    check(nm, int'(size_rd_val), want);
  endtask

  // Requests raised during INIT must produce no response at all.
  task automatic wait_ready(input string nm);
    int n;
    n = 0;
    alloc_req = 1'b1;
    free_req  = 1'b1;
    free_id   = '0;
    do begin
      @(posedge clock);
      #1;
      n++;
      if (n == 3) begin
        alloc_req = 1'b0;
        free_req  = 1'b0;
      end
    end while (!ready && n < 100);
    check(nm, n, 20);
  endtask

  always @(negedge clock) begin
    if (alloc_ack || alloc_fail || free_ack || free_err) begin
      resp_t got, want;
      got.a_ack  = alloc_ack;
      got.a_fail = alloc_fail;
      got.a_id   = alloc_id;
      got.f_ack  = free_ack;
      got.f_err  = free_err;
      n_txn++;
      n_cmp++;
      $display("txn %0d: alloc_ack=%b alloc_fail=%b alloc_id=%0d free_ack=%b free_err=%b",
               n_txn, alloc_ack, alloc_fail, alloc_id, free_ack, free_err);
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL resp_unexpected: actual=%h required=none", got);
      end else begin
        want = exp_q.pop_front();
        if (!want.a_ack) got.a_id = want.a_id;
        if (got !== want) begin
          n_bad++;
          $display("FAIL resp: actual=%h required=%h", got, want);
        end
      end
    end
  end

  initial begin
    reset = 1'b0;
    alloc_req = 1'b0; free_req = 1'b0; free_id = '0;
    size_we = 1'b0; size_id = '0; size_val = '0; size_rd_id = '0;

    // Reset and INIT length
    repeat (3) @(posedge clock);
    #1;
    check("rst_ready", int'(ready), 0);
    check("rst_allocs", int'(allocs), 0);
    check("rst_in_use", int'(in_use), 0);
    check("rst_alloc_id", int'(alloc_id), 0);
    check("rst_size_rd", int'(size_rd_val), 0);
    reset = 1'b1;
    wait_ready("init_len");
    for (int i = 0; i < 20; i++) rd_size(i, 0, "init_size");

    // Fresh ids and LIFO reuse
    for (int i = 0; i < 3; i++) begin
      exp_resp(1, 0, i, 0, 0);
      cyc(1, 0, 0);
    end
    check("t2_allocs", int'(allocs), 3);
    check("t2_in_use", int'(in_use), 3);
    exp_resp(0, 0, 0, 1, 0); cyc(0, 1, 1);
    check("t2_free_in_use", int'(in_use), 2);
    exp_resp(1, 0, 1, 0, 0); cyc(1, 0, 0);
    check("t2_lifo_allocs", int'(allocs), 3);
    check("t2_lifo_in_use", int'(in_use), 3);

    // Range error and double free
    exp_resp(0, 0, 0, 0, 1); cyc(0, 1, 5);
    check("t4_range_in_use", int'(in_use), 3);
    exp_resp(0, 0, 0, 1, 0); cyc(0, 1, 1);
    check("t4_free1_in_use", int'(in_use), 2);
`ifdef ARRAY_ALLOC_DOUBLE_FREE_CHECK_EN
    exp_resp(0, 0, 0, 0, 1); cyc(0, 1, 1);
    check("t4_dbl_in_use", int'(in_use), 2);
    exp_resp(1, 0, 1, 0, 0); cyc(1, 0, 0);
`else
    exp_resp(0, 0, 0, 1, 0); cyc(0, 1, 1);
    check("t4_dbl_in_use", int'(in_use), 1);
    exp_resp(1, 0, 1, 0, 0); cyc(1, 0, 0);
    exp_resp(1, 0, 1, 0, 0); cyc(1, 0, 0);
`endif
    check("t4_restored_in_use", int'(in_use), 3);

    // Size table: clamp, read-before-write, alloc clear wins
    size_we = 1'b1; size_id = 12'd0; size_val = 12'd15; size_rd_id = 12'd0;
    cyc(0, 0, 0);
    check("t5_rd_before_wr", int'(size_rd_val), 0);
    rd_size(0, 10, "t5_clamp");
    size_we = 1'b1; size_id = 12'd2; size_val = 12'd7;
    cyc(0, 0, 0);
    rd_size(2, 7, "t5_unclamped");
    exp_resp(0, 0, 0, 1, 0); cyc(0, 1, 0);
    size_we = 1'b1; size_id = 12'd0; size_val = 12'd5;
    exp_resp(1, 0, 0, 0, 0); cyc(1, 0, 0);
    rd_size(0, 0, "t5_alloc_clear_wins");
    rd_size(2, 7, "t5_other_kept");

    // Exhaustion, fail, bypass, full stack
    for (int i = 3; i < 20; i++) begin
      exp_resp(1, 0, i, 0, 0);
      cyc(1, 0, 0);
    end
    check("t3_allocs_full", int'(allocs), 20);
    check("t3_in_use_full", int'(in_use), 20);
    exp_resp(0, 1, 0, 0, 0); cyc(1, 0, 0);
    check("t3_fail_allocs", int'(allocs), 20);
    exp_resp(1, 0, 7, 1, 0); cyc(1, 1, 7);
    check("t3_bypass_in_use", int'(in_use), 20);
    check("t3_bypass_allocs", int'(allocs), 20);
    for (int i = 0; i < 20; i++) begin
      exp_resp(0, 0, 0, 1, 0);
      cyc(0, 1, i);
    end
    check("t3_all_freed", int'(in_use), 0);
    exp_resp(0, 0, 0, 0, 1); cyc(0, 1, 3);
    check("t3_full_err_in_use", int'(in_use), 0);
    for (int i = 19; i > 15; i--) begin
      exp_resp(1, 0, i, 0, 0);
      cyc(1, 0, 0);
    end
    check("t6_live4", int'(in_use), 4);

    // Reset during READY restarts INIT and id numbering
    cyc(0, 0, 0);
    reset = 1'b0;
    #1;
    check("t6_rst_ready", int'(ready), 0);
    check("t6_rst_allocs", int'(allocs), 0);
    check("t6_rst_in_use", int'(in_use), 0);
    check("t6_rst_alloc_id", int'(alloc_id), 0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    wait_ready("reinit_len");
    rd_size(2, 0, "t6_size_cleared");
    exp_resp(1, 0, 0, 0, 0); cyc(1, 0, 0);
    exp_resp(1, 0, 1, 0, 0); cyc(1, 0, 0);
    check("t6_allocs", int'(allocs), 2);
    check("t6_in_use", int'(in_use), 2);

    cyc(0, 0, 0);
    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
